// File: rtl/avalon_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_arb_pkg
// Description : Shared types, constants and grant-selection helper for the
//               two-master Avalon-MM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [31:0] ERR_READDATA = 32'hDEAD_BEEF;

    // Returns the id of the master to grant; only meaningful when a request exists.
    function automatic logic rr_pick(input logic req0, input logic req1,
                                     input logic last_grant, input logic fixed);
        if (req0 && req1)
            return fixed ? 1'b0 : ~last_grant;
        else if (req0)
            return 1'b0;
        else
            return 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wait_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wait_watchdog
// Description : Counts consecutive stalled cycles of a granted transfer and
//               flags a timeout on the last permitted stalled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wait_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic stall,
    input  logic clear,
    output logic timeout
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] r_count;

            // Saturates at the last value so the counter can never wrap.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    r_count <= '0;
                else if (clear)
                    r_count <= '0;
                else if (active && stall && (r_count != c_LAST))
                    r_count <= r_count + 1'b1;
            end

            assign timeout = active & stall & (r_count == c_LAST);
        end else begin : g_no_wd
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset_n, active, stall, clear};
            assign timeout  = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : avalon_arbiter
// Description : Two-master / one-slave Avalon-MM arbiter with round-robin or
//               fixed priority and a waitrequest watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   m0_address,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [DATA_WIDTH-1:0]   m0_writedata,
    input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
    output logic [DATA_WIDTH-1:0]   m0_readdata,
    output logic                    m0_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   m1_address,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [DATA_WIDTH-1:0]   m1_writedata,
    input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
    output logic [DATA_WIDTH-1:0]   m1_readdata,
    output logic                    m1_waitrequest,
    output logic [ADDR_WIDTH-1:0]   s_address,
    output logic                    s_read,
    output logic                    s_write,
    output logic [DATA_WIDTH-1:0]   s_writedata,
    output logic [DATA_WIDTH/8-1:0] s_byteenable,
    input  logic [DATA_WIDTH-1:0]   s_readdata,
    input  logic                    s_waitrequest,
    output logic                    bus_error,
    output logic                    error_master
);
    import avalon_arb_pkg::*;

    state_t                  r_state, w_next_state;
    logic                    r_last_grant, r_bus_error, r_error_master;
    logic [DATA_WIDTH-1:0]   r_m0_rdata, r_m1_rdata;

    logic                    w_req0, w_req1, w_granted, w_gnt_id, w_req_g;
    logic                    w_timeout, w_leave, w_wait_g;
    logic [DATA_WIDTH-1:0]   w_rdata_g;

    assign w_req0    = m0_read | m0_write;
    assign w_req1    = m1_read | m1_write;
    assign w_granted = (r_state != IDLE);
    assign w_gnt_id  = (r_state == GRANT1);
    assign w_req_g   = w_gnt_id ? w_req1 : w_req0;
    // Any exit from a grant: completion, timeout or the master withdrawing.
    assign w_leave   = w_granted & (~w_req_g | ~s_waitrequest | w_timeout);

    wait_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .active  (w_granted & w_req_g),
        .stall   (s_waitrequest),
        .clear   (~w_granted | w_leave),
        .timeout (w_timeout)
    );

    assign w_wait_g  = s_waitrequest & ~w_timeout;
    assign w_rdata_g = w_timeout ? DATA_WIDTH'(ERR_READDATA) : s_readdata;

    always_comb begin
        w_next_state   = r_state;
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = r_m0_rdata;
        m1_readdata    = r_m1_rdata;

        if (!w_granted) begin
            if (w_req0 || w_req1)
                w_next_state = rr_pick(w_req0, w_req1, r_last_grant, (FIXED_PRIORITY != 0))
                               ? GRANT1 : GRANT0;
        end else begin
            if (w_gnt_id) begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_write        = m1_write & ~w_timeout;
                s_read         = m1_read & ~m1_write & ~w_timeout;
                m1_waitrequest = w_wait_g;
                m1_readdata    = w_rdata_g;
            end else begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_write        = m0_write & ~w_timeout;
                s_read         = m0_read & ~m0_write & ~w_timeout;
                m0_waitrequest = w_wait_g;
                m0_readdata    = w_rdata_g;
            end
            if (w_leave)
                w_next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_last_grant   <= 1'b1;
            r_bus_error    <= 1'b0;
            r_error_master <= 1'b0;
            r_m0_rdata     <= '0;
            r_m1_rdata     <= '0;
        end else begin
            r_state <= w_next_state;
            // A withdrawn request does not count as a turn for round-robin.
            if (w_granted && w_req_g && (!s_waitrequest || w_timeout))
                r_last_grant <= w_gnt_id;
            if (w_timeout) begin
                r_bus_error    <= 1'b1;
                r_error_master <= w_gnt_id;
            end
            if (r_state == GRANT0)
                r_m0_rdata <= m0_readdata;
            if (r_state == GRANT1)
                r_m1_rdata <= m1_readdata;
        end
    end

    assign bus_error    = r_bus_error;
    assign error_master = r_error_master;

endmodule
`default_nettype wire

// File: tb/tb_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_arbiter
// Description : Directed, self-checking bench: a transaction-level model is
//               compared every cycle, plus hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_arbiter;

    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] s_readdata;
    logic        s_waitrequest;

    logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
    logic        m0_waitrequest, m1_waitrequest, s_read, s_write, bus_error, error_master;
    logic [3:0]  s_byteenable;

    logic [31:0] fp_m0_readdata, fp_m1_readdata, fp_s_address, fp_s_writedata;
    logic        fp_m0_wait, fp_m1_wait, fp_s_read, fp_s_write, fp_bus_error, fp_error_master;
    logic [3:0]  fp_s_byteenable;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    avalon_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TB_TIMEOUT),
                     .FIXED_PRIORITY(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .bus_error(bus_error), .error_master(error_master)
    );

    avalon_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TB_TIMEOUT),
                     .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(fp_m0_readdata), .m0_waitrequest(fp_m0_wait),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(fp_m1_readdata), .m1_waitrequest(fp_m1_wait),
        .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
        .s_writedata(fp_s_writedata), .s_byteenable(fp_s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .bus_error(fp_bus_error), .error_master(fp_error_master)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model of the round-robin instance: owner is -1 when idle.
    int          mdl_owner = -1, mdl_last = 1, mdl_stall = 0;
    logic        mdl_err = 1'b0, mdl_errm = 1'b0;
    logic [31:0] mdl_rd [2];
    logic        q0, q1, qx, tmo, e_rd, e_wr, e_w0, e_w1;
    logic [31:0] e_addr, e_wd, e_r0, e_r1;
    logic [3:0]  e_be;

    always @(negedge clk) begin
        if (!reset_n) begin
            mdl_owner = -1; mdl_last = 1; mdl_stall = 0;
            mdl_err = 1'b0; mdl_errm = 1'b0;
            mdl_rd[0] = '0; mdl_rd[1] = '0;
            chk("rst_s_read", s_read, 1'b0);
            chk("rst_s_write", s_write, 1'b0);
            chk("rst_m0_wait", m0_waitrequest, 1'b1);
            chk("rst_m1_wait", m1_waitrequest, 1'b1);
        end else begin
            q0 = m0_read | m0_write;
            q1 = m1_read | m1_write;
            e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0; e_be = '0;
            e_w0 = 1; e_w1 = 1; e_r0 = mdl_rd[0]; e_r1 = mdl_rd[1];
            if (mdl_owner >= 0) begin
                qx  = (mdl_owner == 1) ? q1 : q0;
                tmo = qx && s_waitrequest && (mdl_stall == TB_TIMEOUT - 1);
                e_addr = (mdl_owner == 1) ? m1_address : m0_address;
                e_wd   = (mdl_owner == 1) ? m1_writedata : m0_writedata;
                e_be   = (mdl_owner == 1) ? m1_byteenable : m0_byteenable;
                e_wr   = ((mdl_owner == 1) ? m1_write : m0_write) && !tmo;
                e_rd   = ((mdl_owner == 1) ? m1_read : m0_read) && !e_wr && !tmo
                         && !((mdl_owner == 1) ? m1_write : m0_write);
                if (mdl_owner == 1) begin
                    e_w1 = tmo ? 1'b0 : s_waitrequest;
                    e_r1 = tmo ? 32'hDEAD_BEEF : s_readdata;
                end else begin
                    e_w0 = tmo ? 1'b0 : s_waitrequest;
                    e_r0 = tmo ? 32'hDEAD_BEEF : s_readdata;
                end
            end
            chk("s_read", s_read, e_rd);
            chk("s_write", s_write, e_wr);
            chk("s_address", s_address, e_addr);
            chk("s_writedata", s_writedata, e_wd);
            chk("s_byteenable", {28'd0, s_byteenable}, {28'd0, e_be});
            chk("m0_wait", m0_waitrequest, e_w0);
            chk("m1_wait", m1_waitrequest, e_w1);
            chk("m0_readdata", m0_readdata, e_r0);
            chk("m1_readdata", m1_readdata, e_r1);
            chk("bus_error", bus_error, mdl_err);
            chk("error_master", error_master, mdl_errm);
            if (mdl_owner < 0) begin
                if (q0 && q1)      mdl_owner = 1 - mdl_last;
                else if (q0)       mdl_owner = 0;
                else if (q1)       mdl_owner = 1;
            end else begin
                mdl_rd[mdl_owner] = (mdl_owner == 1) ? e_r1 : e_r0;
                if (!qx) begin
                    mdl_owner = -1; mdl_stall = 0;
                end else if (!s_waitrequest || tmo) begin
                    if (tmo) begin mdl_err = 1'b1; mdl_errm = mdl_owner[0]; end
                    mdl_last = mdl_owner; mdl_owner = -1; mdl_stall = 0;
                end else begin
                    mdl_stall++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 0;
        m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_byteenable = '0; m1_byteenable = '0;
        s_readdata = '0; s_waitrequest = 1;
        step(); step();
        chk("reset_bus_error", bus_error, 1'b0);
        chk("reset_m0_readdata", m0_readdata, 32'h0);
        reset_n = 1;
        step();

        // Single M0 read, slave ready immediately.
        m0_read = 1; m0_address = 32'h10; m0_byteenable = 4'hF;
        s_readdata = 32'h1234_5678; s_waitrequest = 0;
        step();
        chk("t1_m0_wait", m0_waitrequest, 1'b0);
        chk("t1_m0_rdata", m0_readdata, 32'h1234_5678);
        chk("t1_m1_wait", m1_waitrequest, 1'b1);
        chk("t1_s_read", s_read, 1'b1);
        step();
        m0_read = 0; s_readdata = 32'h0;
        chk("t1_rdata_hold", m0_readdata, 32'h1234_5678);
        step();

        // Both masters read continuously; last grant was M0 so M1 goes first.
        m0_read = 1; m1_read = 1; m1_address = 32'h20; m1_byteenable = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            s_readdata = 32'h1000 + k;
            step();
            chk("rr_m0_wait", m0_waitrequest, !(k == 3 || k == 7));
            chk("rr_m1_wait", m1_waitrequest, !(k == 1 || k == 5));
            chk("fp_m0_wait", fp_m0_wait, (k % 2) == 0);
            chk("fp_m1_wait", fp_m1_wait, 1'b1);
        end
        m0_read = 0; m1_read = 0;
        step();

        // M1 write, slave stalls three cycles then accepts.
        m1_write = 1; m1_address = 32'h40; m1_byteenable = 4'b0100;
        m1_writedata = 32'hCAFE_F00D; s_waitrequest = 1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 4) s_waitrequest = 0;
            #1;
            chk("t3_s_write", s_write, 1'b1);
            chk("t3_s_addr", s_address, 32'h40);
            chk("t3_s_wdata", s_writedata, 32'hCAFE_F00D);
            chk("t3_m1_wait", m1_waitrequest, (k != 4));
        end
        step();
        m1_write = 0;
        chk("t3_idle_s_write", s_write, 1'b0);
        step();

        // Stuck slave: watchdog fires on the 8th stalled cycle.
        m0_read = 1; m0_address = 32'h80; s_waitrequest = 1;
        for (int k = 1; k <= TB_TIMEOUT; k++) begin
            step();
            chk("t4_m0_wait", m0_waitrequest, (k != TB_TIMEOUT));
        end
        chk("t4_err_rdata", m0_readdata, 32'hDEAD_BEEF);
        chk("t4_s_read", s_read, 1'b0);
        step();
        m0_read = 0;
        chk("t4_bus_error", bus_error, 1'b1);
        chk("t4_error_master", error_master, 1'b0);
        m1_read = 1; m1_address = 32'h84; s_waitrequest = 0; s_readdata = 32'h55AA_55AA;
        step();
        chk("t4_m1_wait", m1_waitrequest, 1'b0);
        chk("t4_m1_rdata", m1_readdata, 32'h55AA_55AA);
        step();
        m1_read = 0;
        step();

        // Reset pulsed during a stalled M1 grant.
        m1_write = 1; s_waitrequest = 1;
        step();
        step();
        #2 reset_n = 0;
        #1;
        chk("t5_s_write", s_write, 1'b0);
        chk("t5_s_read", s_read, 1'b0);
        chk("t5_m0_wait", m0_waitrequest, 1'b1);
        chk("t5_m1_wait", m1_waitrequest, 1'b1);
        chk("t5_bus_error", bus_error, 1'b0);
        m1_write = 0;
        step(); step();
        reset_n = 1; m0_read = 1; m1_read = 1; s_waitrequest = 0;
        step();
        chk("t5_m0_first", m0_waitrequest, 1'b0);
        chk("t5_m1_held", m1_waitrequest, 1'b1);
        step();
        m0_read = 0; m1_read = 0;
        step();

        // M0 withdraws mid-grant; round-robin turn is not consumed.
        m0_read = 1; s_waitrequest = 1;
        step();
        chk("t6_m0_wait", m0_waitrequest, 1'b1);
        m0_read = 0;
        #1;
        chk("t6_s_read", s_read, 1'b0);
        step();
        chk("t6_idle_m0_wait", m0_waitrequest, 1'b1);
        chk("t6_bus_error", bus_error, 1'b0);
        m0_read = 1; m1_read = 1; s_waitrequest = 0; s_readdata = 32'h0BAD_F00D;
        step();
        chk("t6_m1_turn", m1_waitrequest, 1'b0);
        chk("t6_fp_m0", fp_m0_wait, 1'b0);
        step();
        m0_read = 0; m1_read = 0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avalon_arbiter.md
Name: avalon_arbiter

Overview:
- Two-master, one-slave Avalon-MM arbiter in front of the shared memory.
- Master 0 (M0) is the CPU bus controller. Master 1 (M1) is the loader/DMA/testbench port.
- Grants one master at a time and holds the grant until the slave completes the transfer.
- A waitrequest watchdog aborts hung transfers and records a sticky error.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byteenable width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, maximum consecutive stalled cycles in a grant; 0 disables the watchdog.
- FIXED_PRIORITY, 0, 1 = M0 always wins; 0 = round-robin.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_address  in  ADDR_WIDTH  M0 word address.
- m0_read / m0_write  in  1 each  M0 request strobes.
- m0_writedata  in  DATA_WIDTH  M0 write data.
- m0_byteenable  in  DATA_WIDTH/8  M0 byte lanes.
- m0_readdata  out  DATA_WIDTH  M0 read data.
- m0_waitrequest  out  1  M0 stall.
- m1_address / m1_read / m1_write / m1_writedata / m1_byteenable  in  as for M0  M1 request.
- m1_readdata  out  DATA_WIDTH  M1 read data.
- m1_waitrequest  out  1  M1 stall.
- s_address  out  ADDR_WIDTH  to slave.
- s_read / s_write  out  1 each  to slave.
- s_writedata  out  DATA_WIDTH  to slave.
- s_byteenable  out  DATA_WIDTH/8  to slave.
- s_readdata  in  DATA_WIDTH  from slave.
- s_waitrequest  in  1  from slave.
- bus_error  out  1  sticky: a watchdog timeout occurred.
- error_master  out  1  master id of the last timeout.

Behaviour:
- Reset (async on reset_n low):
  - state=IDLE, last_grant=1 (so M0 wins first), wd_count=0, bus_error=0, error_master=0.
  - Outputs under reset: s_read=s_write=0, m0_waitrequest=m1_waitrequest=1.
  - Reset asserted mid-transfer drops the slave strobes immediately; no completion is signalled to either master.
- Request definition: reqX = mX_read | mX_write. Read and write asserted together is illegal; the write takes priority and the read is ignored.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - Slave strobes are 0; s_address, s_writedata and s_byteenable are 0.
  - Both waitrequests are 1.
  - Next state: both requesting -> with FIXED_PRIORITY=1, GRANT0; otherwise the master != last_grant. Only one requesting -> that master. None -> stay in IDLE.
  - Arbitration latency is 1 cycle. No master completes in IDLE.
- GRANTx:
  - s_* combinationally mirror mX_*.
  - mX_waitrequest = s_waitrequest; the other master's waitrequest = 1.
  - mX_readdata = s_readdata; the non-granted readdata holds its last registered value (0 after reset).
- Completion: in GRANTx with s_waitrequest=0, the transfer completes that cycle. Then last_grant<=x, wd_count<=0, next state IDLE.
  - A minimum of 2 cycles per transfer; back-to-back requests alternate under round-robin.
- Request withdrawn while granted (reqX=0 in GRANTx): protocol violation. Slave strobes follow the master (0), next state IDLE, last_grant unchanged.
- Watchdog (TIMEOUT_CYCLES>0):
  - wd_count increments each GRANTx cycle with s_waitrequest=1.
  - When wd_count==TIMEOUT_CYCLES-1 and s_waitrequest=1, a forced completion occurs:
    - mX_waitrequest=0 that cycle; mX_readdata=ERR_READDATA (32'hDEAD_BEEF).
    - s_read=s_write=0 that cycle.
    - bus_error<=1, error_master<=x, last_grant<=x, next state IDLE.
  - If the slave completes on the same cycle as the timeout, it is a normal completion with no error.
  - bus_error clears only on reset.
- Counter width is clog2(TIMEOUT_CYCLES+1) and the counter never wraps.
- No transfer is ever issued to the slave on behalf of a non-granted master.

Decomposition:
- Package avalon_arb_pkg:
  - state_t enum {IDLE, GRANT0, GRANT1}.
  - ERR_READDATA constant.
  - function rr_pick(req0, req1, last_grant, fixed) returning the grant id.
- Sub-module wait_watchdog: params TIMEOUT_CYCLES; ports clk, reset_n, active, stall, clear, timeout. Instantiated once.
- All muxing and the FSM stay in avalon_arbiter.

Test Plan:
- Single M0 read: slave readdata=32'h1234_5678, waitrequest low immediately -> GRANT0 on cycle 1, m0_readdata=32'h1234_5678 with m0_waitrequest=0 on cycle 1; m1_waitrequest=1 throughout.
- Simultaneous continuous M0 and M1 reads, FIXED_PRIORITY=0 -> grants M0, M1, M0, M1, each completion 2 cycles apart; FIXED_PRIORITY=1 -> M0 only, M1 starved.
- M1 write addr 32'h40, byteenable 4'b0100, slave stalls 3 cycles -> s_write held 4 cycles with stable address/data; m1_waitrequest tracks s_waitrequest; state returns to IDLE afterwards.
- TIMEOUT_CYCLES=8, slave waitrequest stuck high on an M0 read -> on the 8th stalled cycle m0_waitrequest=0, m0_readdata=32'hDEAD_BEEF, bus_error=1, error_master=0; the next M1 request is served normally.
- reset_n pulsed low during GRANT1 with slave stalled -> s_write/s_read=0 asynchronously, both waitrequests=1; after release, M0 is granted first when both request.
- M0 drops m0_read mid-grant -> state returns to IDLE next cycle; last_grant unchanged; bus_error stays 0.
